// File: rtl/pc_unit_ras_pkg.sv
// Shared types and default sizing for the program-counter unit and its return-address stack.
package pc_pkg;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_JR   = 2'b01,
        JMP_JAL  = 2'b10,
        JMP_J    = 2'b11
    } jump_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_RSVD = 2'b11
    } branch_e;

    localparam int DEFAULT_WORD_SIZE = 32;
    localparam int DEFAULT_J_W       = 26;
    localparam int DEFAULT_RAS_DEPTH = 4;
    localparam int RAS_PTR_W         = $clog2(DEFAULT_RAS_DEPTH);

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control/status bundle between the decode stage and the PC unit; the PC unit is the slave.
interface pc_unit_ras_if #(
    parameter int WORD_SIZE = 32,
    parameter int J_W       = 26
);
    logic                 stall;
    logic                 redirect;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic [1:0]           branch;
    logic [1:0]           jump;
    logic                 equal;
    logic [WORD_SIZE-1:0] branch_off;
    logic [J_W-1:0]       j_field;
    logic [WORD_SIZE-1:0] jr_target;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] pc_next;
    logic                 taken;
    logic [WORD_SIZE-1:0] ras_top;
    logic                 ras_valid;
    logic                 ras_mispredict;
    logic                 ras_overflow;

    modport master (
        output stall, redirect, redirect_pc, branch, jump, equal, branch_off, j_field, jr_target,
        input  pc, pc_next, taken, ras_top, ras_valid, ras_mispredict, ras_overflow
    );

    modport slave (
        input  stall, redirect, redirect_pc, branch, jump, equal, branch_off, j_field, jr_target,
        output pc, pc_next, taken, ras_top, ras_valid, ras_mispredict, ras_overflow
    );
endinterface

// File: rtl/pc_unit_ras_ras.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [WORD_SIZE-1:0] push_data_i,
    output logic [WORD_SIZE-1:0] top_o,
    output logic                 valid_o,
    output logic                 overflow_o
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WORD_SIZE-1:0] entries_q [RAS_DEPTH];
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 overflow_q;
    logic [PTR_W-1:0]     topIdx;
    logic                 full;

    // ptr_q points at the next free slot, so the top lives one below it (mod depth).
    assign topIdx  = ptr_q - PTR_W'(1);
    assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
    assign valid_o = (cnt_q != '0);
    assign top_o   = valid_o ? entries_q[topIdx] : '0;
    assign overflow_o = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) entries_q[i] <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else if (push_i) begin
            entries_q[ptr_q] <= push_data_i;
            ptr_q            <= ptr_q + PTR_W'(1);
            if (full) overflow_q <= 1'b1;
            else      cnt_q      <= cnt_q + CNT_W'(1);
        end else if (pop_i && valid_o) begin
            ptr_q <= topIdx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end
endmodule

// File: rtl/pc_unit_ras.sv
// PC register and next-PC selection at the head of IF, with a return-address stack for jal/jr.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int          WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int          J_W       = DEFAULT_J_W,
    parameter int          RAS_DEPTH = DEFAULT_RAS_DEPTH,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input logic           clk,
    input logic           rst_n,
    pc_unit_ras_if.slave  bus
);
    logic [WORD_SIZE-1:0] pc_q;
    logic [WORD_SIZE-1:0] pc_d;
    logic [WORD_SIZE-1:0] pcPlus1;
    logic                 branchTaken;
    logic                 rasAct;
    logic                 rasValid;
    logic [WORD_SIZE-1:0] rasTop;
    jump_e                jumpSel;
    branch_e              branchSel;

    assign jumpSel   = jump_e'(bus.jump);
    assign branchSel = branch_e'(bus.branch);
    assign pcPlus1   = pc_q + WORD_SIZE'(1);
    assign branchTaken = (branchSel == BR_BEQ &&  bus.equal) ||
                         (branchSel == BR_BNE && !bus.equal);

    // Priority: redirect, then any jump (which masks a simultaneous branch), then branch, then pc+1.
    always_comb begin
        pc_d = pcPlus1;
        if (bus.redirect)                          pc_d = bus.redirect_pc;
        else if (jumpSel == JMP_J || jumpSel == JMP_JAL)
                                                   pc_d = {pc_q[WORD_SIZE-1:J_W], bus.j_field};
        else if (jumpSel == JMP_JR)                pc_d = bus.jr_target;
        else if (branchTaken)                      pc_d = pcPlus1 + bus.branch_off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pc_q <= RESET_PC[WORD_SIZE-1:0];
        else if (bus.redirect) pc_q <= bus.redirect_pc;
        else if (!bus.stall)   pc_q <= pc_d;
    end

    assign rasAct = !bus.stall && !bus.redirect;

    pc_ras #(
        .WORD_SIZE (WORD_SIZE),
        .RAS_DEPTH (RAS_DEPTH)
    ) uRas (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rasAct && jumpSel == JMP_JAL),
        .pop_i       (rasAct && jumpSel == JMP_JR),
        .push_data_i (pcPlus1),
        .top_o       (rasTop),
        .valid_o     (rasValid),
        .overflow_o  (bus.ras_overflow)
    );

    assign bus.pc             = pc_q;
    assign bus.pc_next        = pc_d;
    assign bus.taken          = bus.redirect || jumpSel != JMP_NONE || branchTaken;
    assign bus.ras_top        = rasTop;
    assign bus.ras_valid      = rasValid;
    assign bus.ras_mispredict = jumpSel == JMP_JR && rasValid && rasTop != bus.jr_target;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: a vector table for next-PC selection plus hand-written RAS/reset sequences.
module tb_pc_unit_ras;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_unit_ras_if #(.WORD_SIZE(32), .J_W(26)) bus ();

    pc_unit_ras #(
        .WORD_SIZE (32),
        .J_W       (26),
        .RAS_DEPTH (4),
        .RESET_PC  (32'd0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] startPc;
        logic        redirect;
        logic [31:0] redirectPc;
        logic        stall;
        logic [1:0]  branch;
        logic [1:0]  jump;
        logic        equal;
        logic [31:0] branchOff;
        logic [25:0] jField;
        logic [31:0] jrTarget;
        logic [31:0] expNext;
        logic        expTaken;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs [13];

    task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic st,
                                 input logic [1:0] br, input logic [1:0] jp, input logic eq,
                                 input logic [31:0] off, input logic [25:0] jf, input logic [31:0] jrt);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.stall       = st;
        bus.branch      = br;
        bus.jump        = jp;
        bus.equal       = eq;
        bus.branch_off  = off;
        bus.j_field     = jf;
        bus.jr_target   = jrt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idle();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic jal(input logic [25:0] jf);
        applyStimulus(1'b0, 32'd0, 1'b0, 2'b00, 2'b10, 1'b0, 32'd0, jf, 32'd0);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;

        vecs[0]  = '{"beq_taken",     32'h10, 0, 32'h0, 0, 2'b01, 2'b00, 1, 32'hFFFF_FFFC, 26'h0, 32'h0, 32'h0D, 1, 32'h0D};
        vecs[1]  = '{"bne_not_taken", 32'h10, 0, 32'h0, 0, 2'b10, 2'b00, 1, 32'hFFFF_FFFC, 26'h0, 32'h0, 32'h11, 0, 32'h11};
        vecs[2]  = '{"br_reserved",   32'h10, 0, 32'h0, 0, 2'b11, 2'b00, 1, 32'hFFFF_FFFC, 26'h0, 32'h0, 32'h11, 0, 32'h11};
        vecs[3]  = '{"bne_taken",     32'h10, 0, 32'h0, 0, 2'b10, 2'b00, 0, 32'd5,        26'h0, 32'h0, 32'h16, 1, 32'h16};
        vecs[4]  = '{"beq_not_taken", 32'h10, 0, 32'h0, 0, 2'b01, 2'b00, 0, 32'd5,        26'h0, 32'h0, 32'h11, 0, 32'h11};
        vecs[5]  = '{"j_upper_bits",  32'hFC00_0010, 0, 32'h0, 0, 2'b00, 2'b11, 0, 32'h0, 26'h123, 32'h0, 32'hFC00_0123, 1, 32'hFC00_0123};
        vecs[6]  = '{"jump_over_br",  32'h20, 0, 32'h0, 0, 2'b01, 2'b11, 1, 32'd3,        26'h40, 32'h0, 32'h40, 1, 32'h40};
        vecs[7]  = '{"jr_empty_ras",  32'h10, 0, 32'h0, 0, 2'b00, 2'b01, 0, 32'h0,        26'h0, 32'h1234, 32'h1234, 1, 32'h1234};
        vecs[8]  = '{"redirect_wins", 32'h10, 1, 32'h80, 0, 2'b00, 2'b11, 0, 32'h0,       26'h55, 32'h0, 32'h80, 1, 32'h80};
        vecs[9]  = '{"stall_hold",    32'h10, 0, 32'h0, 1, 2'b01, 2'b00, 1, 32'hFFFF_FFFC, 26'h0, 32'h0, 32'h0D, 1, 32'h10};
        vecs[10] = '{"seq_wrap",      32'hFFFF_FFFF, 0, 32'h0, 0, 2'b00, 2'b00, 0, 32'h0, 26'h0, 32'h0, 32'h0, 0, 32'h0};
        vecs[11] = '{"beq_wrap",      32'hFFFF_FFFF, 0, 32'h0, 0, 2'b01, 2'b00, 1, 32'd1, 26'h0, 32'h0, 32'h1, 1, 32'h1};
        vecs[12] = '{"stall_redir",   32'h10, 1, 32'h80, 1, 2'b00, 2'b00, 0, 32'h0,       26'h0, 32'h0, 32'h80, 1, 32'h80};

        // Reset and straight-line fetch
        doReset();
        checkOutput("reset_pc", bus.pc, 32'h0);
        checkOutput("reset_ras_valid", {31'd0, bus.ras_valid}, 32'd0);
        checkOutput("reset_ras_top", bus.ras_top, 32'h0);
        checkOutput("reset_overflow", {31'd0, bus.ras_overflow}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("seq_taken", {31'd0, bus.taken}, 32'd0);
            tick();
            checkOutput("seq_pc", bus.pc, 32'(i));
        end

        // Next-PC selection table; each vector first redirects to its start PC
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, vecs[i].startPc, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
            tick();
            applyStimulus(vecs[i].redirect, vecs[i].redirectPc, vecs[i].stall, vecs[i].branch,
                          vecs[i].jump, vecs[i].equal, vecs[i].branchOff, vecs[i].jField, vecs[i].jrTarget);
            #1;
            checkOutput({vecs[i].name, "_next"}, bus.pc_next, vecs[i].expNext);
            checkOutput({vecs[i].name, "_taken"}, {31'd0, bus.taken}, {31'd0, vecs[i].expTaken});
            tick();
            checkOutput({vecs[i].name, "_pc"}, bus.pc, vecs[i].expPc);
        end

        // jal pushes return address, jr pops it
        doReset();
        applyStimulus(1'b1, 32'hFC00_0010, 1'b0, 2'b00, 2'b00, 1'b0, 32'd0, 26'd0, 32'd0);
        tick();
        jal(26'h123);
        checkOutput("jal_pc", bus.pc, 32'hFC00_0123);
        checkOutput("jal_top", bus.ras_top, 32'hFC00_0011);
        checkOutput("jal_valid", {31'd0, bus.ras_valid}, 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 2'b00, 2'b01, 1'b0, 32'd0, 26'd0, 32'hFC00_0011);
        #1;
        checkOutput("jr_mispredict", {31'd0, bus.ras_mispredict}, 32'd0);
        tick();
        checkOutput("jr_pc", bus.pc, 32'hFC00_0011);
        checkOutput("jr_valid_after_pop", {31'd0, bus.ras_valid}, 32'd0);

        // Five pushes into a four-deep RAS, then drain and underflow
        doReset();
        idle();
        tick();
        for (int k = 1; k <= 5; k++) begin
            checkOutput("wrap_jal_from", bus.pc, 32'(k));
            checkOutput("wrap_overflow_pre", {31'd0, bus.ras_overflow}, 32'd0);
            jal(26'(k + 1));
        end
        checkOutput("wrap_overflow", {31'd0, bus.ras_overflow}, 32'd1);
        for (int k = 6; k >= 3; k--) begin
            logic [31:0] target;
            target = (k == 3) ? 32'h99 : 32'(k);
            applyStimulus(1'b0, 32'd0, 1'b0, 2'b00, 2'b01, 1'b0, 32'd0, 26'd0, target);
            #1;
            checkOutput("wrap_pop_top", bus.ras_top, 32'(k));
            checkOutput("wrap_pop_mispredict", {31'd0, bus.ras_mispredict}, (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        checkOutput("drained_valid", {31'd0, bus.ras_valid}, 32'd0);
        checkOutput("drained_top", bus.ras_top, 32'h0);
        applyStimulus(1'b0, 32'd0, 1'b0, 2'b00, 2'b01, 1'b0, 32'd0, 26'd0, 32'h50);
        #1;
        checkOutput("underflow_mispredict", {31'd0, bus.ras_mispredict}, 32'd0);
        tick();
        checkOutput("underflow_pc", bus.pc, 32'h50);
        checkOutput("underflow_valid", {31'd0, bus.ras_valid}, 32'd0);
        checkOutput("underflow_overflow_sticky", {31'd0, bus.ras_overflow}, 32'd1);

        // Stall and redirect leave the RAS alone
        doReset();
        applyStimulus(1'b0, 32'd0, 1'b1, 2'b00, 2'b10, 1'b0, 32'd0, 26'h40, 32'd0);
        tick();
        checkOutput("stall_jal_pc", bus.pc, 32'h0);
        checkOutput("stall_jal_valid", {31'd0, bus.ras_valid}, 32'd0);
        jal(26'h40);
        checkOutput("jal_after_stall_pc", bus.pc, 32'h40);
        checkOutput("jal_after_stall_top", bus.ras_top, 32'h1);
        applyStimulus(1'b1, 32'h80, 1'b1, 2'b00, 2'b01, 1'b0, 32'd0, 26'd0, 32'h1);
        tick();
        checkOutput("stall_redirect_pc", bus.pc, 32'h80);
        checkOutput("stall_redirect_valid", {31'd0, bus.ras_valid}, 32'd1);
        checkOutput("stall_redirect_top", bus.ras_top, 32'h1);

        // Asynchronous reset between edges
        doReset();
        jal(26'h10);
        jal(26'h20);
        jal(26'h30);
        checkOutput("pre_reset_pc", bus.pc, 32'h30);
        checkOutput("pre_reset_valid", {31'd0, bus.ras_valid}, 32'd1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pc", bus.pc, 32'h0);
        checkOutput("async_reset_valid", {31'd0, bus.ras_valid}, 32'd0);
        checkOutput("async_reset_top", bus.ras_top, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_fetch", bus.pc, 32'h0);
        tick();
        checkOutput("post_reset_seq", bus.pc, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
